mem_port_arbiter: RTL

Arbiter and sequencer for a single-ported memory shared by the pipeline's instruction-fetch stage and its data-memory stage. It accepts one request per requester, grants one at a time and drives the memory port for a fixed-latency access. It returns read data with a one-cycle acknowledge and generates per-stage stall signals that freeze the PC and the pipeline buffers until the access completes. It sits between the IF/MEM stages and the shared memory macro.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/arb_lat_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared state/grant types and default timing constants
// Revision    : 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  localparam int c_DEF_MEM_LAT    = 2;
  localparam int c_DEF_STARVE_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data and memory-macro signals of the arbiter
// Revision            : 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  // Requesters and the memory macro together form the environment side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/arb_lat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb_lat_counter : loadable down-counter flagging the final latency cycle
// Revision        : 1.0
// ----------------------------------------------------------------------------
module arb_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);
  localparam int                 c_CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(MEM_LAT);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_LOAD;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  assign o_last = (r_cnt == c_ONE);
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : fetch/data arbiter and fixed-latency memory sequencer.
// Optional macro ARB_STARVE_GUARD_EN enables the fetch starvation guard.
// Revision         : 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = c_DEF_MEM_LAT,
  parameter int STARVE_MAX = c_DEF_STARVE_MAX
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
  localparam logic [1:0] c_ST_ISSUE = ST_ISSUE;
  localparam logic [1:0] c_ST_WAIT  = ST_WAIT;
  localparam logic [1:0] c_ST_DONE  = ST_DONE;

  if (MEM_LAT < 1) begin : g_chk_mem_lat
    $error("MEM_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_chk_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic [1:0]        r_state;
  gnt_e              r_gnt;
  logic              r_d_we;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_starve_hit;
  logic              w_last;
  logic              w_grant;
  gnt_e              w_gnt;

  assign w_any_req = bus.if_req | bus.d_req;
  assign w_grant   = (r_state == c_ST_IDLE) && w_any_req;
  // Data belongs to the older instruction, so it wins unless fetch is starved.
  assign w_gnt     = (bus.if_req && (!bus.d_req || w_starve_hit)) ? GNT_IF : GNT_D;

`ifdef ARB_STARVE_GUARD_EN
  localparam int                    c_STARVE_W  = $clog2(STARVE_MAX + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);
  localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

  logic [c_STARVE_W-1:0] r_starve_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      if ((w_gnt == GNT_IF) || !bus.if_req) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != c_STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
      end
    end
  end

  assign w_starve_hit = (r_starve_cnt == c_STARVE_LIM);
`else
  assign w_starve_hit = 1'b0;
`endif

  arb_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == c_ST_ISSUE),
    .i_dec  (r_state == c_ST_WAIT),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_gnt       <= GNT_IF;
      r_d_we      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_req) begin
            r_state  <= c_ST_ISSUE;
            r_gnt    <= w_gnt;
            r_mem_en <= 1'b1;
            if (w_gnt == GNT_D) begin
              r_d_we      <= bus.d_we;
              r_mem_we    <= bus.d_we;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
            end else begin
              r_d_we      <= 1'b0;
              r_mem_addr  <= bus.if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        c_ST_ISSUE: begin
          r_state <= c_ST_WAIT;
        end
        c_ST_WAIT: begin
          // Final latency cycle: memory data is valid now; ack lands in DONE.
          if (w_last) begin
            r_state <= c_ST_DONE;
            if (r_gnt == GNT_D) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= r_d_we ? '0 : bus.mem_rdata;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_ack;
  assign bus.stall_mem = bus.d_req & ~r_d_ack;
endmodule
`default_nettype wire
